// File: rtl/simd_multiplier_pipelined.sv
// simd_multiplier_pipelined
// Pipelined signed/unsigned multiplier with a per-transaction SIMD split:
// one WxW lane, two (W/2)x(W/2) lanes or four (W/4)x(W/4) lanes.
// Global-stall valid/ready pipeline of LATENCY register stages.
// Optional feature macro: SIMD_MUL_ACC_EN adds in_acc and a lane-wise
// accumulator on the final stage (out_data = accumulator).
module simd_multiplier_pipelined #(
  parameter int W       = 16,
  parameter int LATENCY = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  input  logic [1:0]     in_mode,
  input  logic           in_a_sign,
  input  logic           in_b_sign,
`ifdef SIMD_MUL_ACC_EN
  input  logic           in_acc,
`endif
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_data,
  output logic [1:0]     out_mode
);

  localparam int H = W / 2;
  localparam int Q = W / 4;

  localparam logic [1:0] MODE_FULL = 2'b00;
  localparam logic [1:0] MODE_HALF = 2'b01;
  localparam logic [1:0] MODE_QUAD = 2'b10;

`ifdef SIMD_MUL_ACC_EN
  // Lane-wise modulo add: the carry chain is cut at every lane boundary
  // of the given mode so no lane ever spills into its neighbour.
  function automatic logic [2*W-1:0] lane_add(input logic [2*W-1:0] x,
                                              input logic [2*W-1:0] y,
                                              input logic [1:0]     m);
    logic [2*W-1:0] s;
    logic           c;
    s = '0;
    c = 1'b0;
    for (int i = 0; i < 2*W; i++) begin
      if ((m == MODE_QUAD && (i % H) == 0) || (m == MODE_HALF && (i % W) == 0))
        c = 1'b0;
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return s;
  endfunction
`endif

  // The whole pipeline moves only when the output slot is free or drained.
  logic advance;
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  // ---- stage p0: lane products formed from the operands being accepted ----
  logic [1:0]     mode_p0;
  logic [2*W-1:0] prod_full;
  logic [2*W-1:0] prod_half;
  logic [2*W-1:0] prod_quad;
  logic [2*W-1:0] prod_p0;

  assign mode_p0 = (in_mode == 2'b11) ? MODE_FULL : in_mode;

  // Each lane operand is sign-extended (when its sign flag is set) to the
  // product width, so the truncated product is exact for any sign mix.
  logic signed [2*W-1:0] full_a;
  logic signed [2*W-1:0] full_b;
  assign full_a    = {{W{in_a_sign & in_a[W-1]}}, in_a};
  assign full_b    = {{W{in_b_sign & in_b[W-1]}}, in_b};
  assign prod_full = full_a * full_b;

  for (genvar i = 0; i < 2; i++) begin : g_half
    logic signed [W-1:0] la;
    logic signed [W-1:0] lb;
    assign la = {{H{in_a_sign & in_a[i*H+H-1]}}, in_a[i*H +: H]};
    assign lb = {{H{in_b_sign & in_b[i*H+H-1]}}, in_b[i*H +: H]};
    assign prod_half[i*W +: W] = la * lb;
  end

  for (genvar i = 0; i < 4; i++) begin : g_quad
    logic signed [H-1:0] la;
    logic signed [H-1:0] lb;
    assign la = {{Q{in_a_sign & in_a[i*Q+Q-1]}}, in_a[i*Q +: Q]};
    assign lb = {{Q{in_b_sign & in_b[i*Q+Q-1]}}, in_b[i*Q +: Q]};
    assign prod_quad[i*H +: H] = la * lb;
  end

  // Select the lane layout requested by this transaction.
  always_comb begin
    prod_p0 = prod_full;
    case (mode_p0)
      MODE_HALF: prod_p0 = prod_half;
      MODE_QUAD: prod_p0 = prod_quad;
      default:   prod_p0 = prod_full;
    endcase
  end

  // ---- stages p1..pN: valid shift chain, cleared by reset ----
  logic vld_pn [0:LATENCY-1];

  // Valid bits shift one stage per advance; bubbles are kept, not squeezed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LATENCY; k++) vld_pn[k] <= 1'b0;
    end else if (advance) begin
      vld_pn[0] <= in_valid;
      for (int k = 1; k < LATENCY; k++) vld_pn[k] <= vld_pn[k-1];
    end
  end

  assign out_valid = vld_pn[LATENCY-1];

  // Signals feeding the final (output) register.
  logic           fin_vld;
  logic [2*W-1:0] fin_prod;
  logic [1:0]     fin_mode;
`ifdef SIMD_MUL_ACC_EN
  logic           fin_acc;
`endif

  if (LATENCY == 1) begin : g_direct
    assign fin_vld  = in_valid;
    assign fin_prod = prod_p0;
    assign fin_mode = mode_p0;
`ifdef SIMD_MUL_ACC_EN
    assign fin_acc  = in_acc;
`endif
  end else begin : g_stages
    logic [2*W-1:0] prod_pn [0:LATENCY-2];
    logic [1:0]     mode_pn [0:LATENCY-2];
`ifdef SIMD_MUL_ACC_EN
    logic           acc_pn  [0:LATENCY-2];
`endif

    // Intermediate data registers advance in lockstep with the valid chain.
    always_ff @(posedge clk) begin
      if (advance) begin
        prod_pn[0] <= prod_p0;
        mode_pn[0] <= mode_p0;
`ifdef SIMD_MUL_ACC_EN
        acc_pn[0]  <= in_acc;
`endif
        for (int k = 1; k < LATENCY-1; k++) begin
          prod_pn[k] <= prod_pn[k-1];
          mode_pn[k] <= mode_pn[k-1];
`ifdef SIMD_MUL_ACC_EN
          acc_pn[k]  <= acc_pn[k-1];
`endif
        end
      end
    end

    assign fin_vld  = vld_pn[LATENCY-2];
    assign fin_prod = prod_pn[LATENCY-2];
    assign fin_mode = mode_pn[LATENCY-2];
`ifdef SIMD_MUL_ACC_EN
    assign fin_acc  = acc_pn[LATENCY-2];
`endif
  end

  // ---- final stage: output register, loaded only by valid transactions ----
  // Holding on bubbles keeps out_data defined and stable when out_valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_mode <= MODE_FULL;
    end else if (advance && fin_vld) begin
      out_mode <= fin_mode;
`ifdef SIMD_MUL_ACC_EN
      out_data <= fin_acc ? lane_add(out_data, fin_prod, fin_mode) : fin_prod;
`else
      out_data <= fin_prod;
`endif
    end
  end

endmodule
